// File: rtl/mfgate_pkg.sv
// Shared definitions for the multifunction-gate decoder family: function codes,
// candidate-mask bit positions and the decoder state type.
package mfgate_pkg;

  localparam logic [1:0] MODE_PASS_X = 2'b00;
  localparam logic [1:0] MODE_INV_X  = 2'b11;
  localparam logic [1:0] MODE_PASS_Y = 2'b01;

  localparam int CAND_X  = 0;
  localparam int CAND_NX = 1;
  localparam int CAND_Y  = 2;

  typedef enum logic [1:0] {
    SEARCH,
    CONFIRM,
    LOCKED,
    ERROR
  } state_t;

  // ab=01 and ab=10 both behave as PASS_Y, so PASS_Y is always reported as 01.
  function automatic logic [1:0] cand_to_mode(input logic [2:0] c);
    logic [1:0] code;
    code = MODE_PASS_X;
    if (c[CAND_NX]) code = MODE_INV_X;
    else if (c[CAND_Y]) code = MODE_PASS_Y;
    return code;
  endfunction

  function automatic logic is_one_hot(input logic [2:0] c);
    return (c == 3'b001) || (c == 3'b010) || (c == 3'b100);
  endfunction

endpackage

// File: rtl/mfgate_match.sv
// Per-sample consistency test: which gate functions could have produced f
// from the observed x and y.
module mfgate_match
  import mfgate_pkg::*;
(
  input  logic       x,
  input  logic       y,
  input  logic       f,
  output logic [2:0] m
);

  assign m[CAND_X]  = (f == x);
  assign m[CAND_NX] = (f == ~x);
  assign m[CAND_Y]  = (f == y);

endmodule

// File: rtl/mfgate_mode_decoder.sv
// Recovers which function an mfGate instance implements by narrowing a
// candidate set over accepted (x, y, f) samples, then locks and keeps checking.
module mfgate_mode_decoder
  import mfgate_pkg::*;
#(
  parameter int CONFIRM_LEN = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x,
  input  logic             y,
  input  logic             f,
  output logic [2:0]       cand,
  output logic             mode_valid,
  output logic [1:0]       mode,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam logic [7:0] CONF_TARGET = 8'(CONFIRM_LEN);

  state_t           state_reg, state_next;
  logic [2:0]       cand_reg, cand_next;
  logic [7:0]       conf_cnt_reg, conf_cnt_next;
  logic [1:0]       mode_reg, mode_next;
  logic             mode_valid_reg, mode_valid_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] sample_cnt_reg, sample_cnt_next;

  logic [2:0] m;
  logic [2:0] narrowed;
  logic       accept;

  mfgate_match u_match (
    .x (x),
    .y (y),
    .f (f),
    .m (m)
  );

  assign in_ready = (state_reg != ERROR) && !clr;
  assign accept   = in_valid && in_ready;
  assign narrowed = cand_reg & m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= SEARCH;
      cand_reg       <= 3'b111;
      conf_cnt_reg   <= 8'd0;
      mode_reg       <= MODE_PASS_X;
      mode_valid_reg <= 1'b0;
      err_reg        <= 1'b0;
      sample_cnt_reg <= '0;
    end else begin
      state_reg      <= state_next;
      cand_reg       <= cand_next;
      conf_cnt_reg   <= conf_cnt_next;
      mode_reg       <= mode_next;
      mode_valid_reg <= mode_valid_next;
      err_reg        <= err_next;
      sample_cnt_reg <= sample_cnt_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cand_next       = cand_reg;
    conf_cnt_next   = conf_cnt_reg;
    mode_next       = mode_reg;
    mode_valid_next = mode_valid_reg;
    err_next        = err_reg;
    sample_cnt_next = sample_cnt_reg;

    if (clr) begin
      state_next      = SEARCH;
      cand_next       = 3'b111;
      conf_cnt_next   = 8'd0;
      mode_next       = MODE_PASS_X;
      mode_valid_next = 1'b0;
      err_next        = 1'b0;
      sample_cnt_next = '0;
    end else if (accept) begin
      if (sample_cnt_reg != '1) sample_cnt_next = sample_cnt_reg + 1'b1;

      // Any sample that empties the candidate set is fatal, whatever the state.
      if (narrowed == 3'b000 || (state_reg != SEARCH && narrowed != cand_reg)) begin
        state_next      = ERROR;
        cand_next       = 3'b000;
        mode_valid_next = 1'b0;
        err_next        = 1'b1;
      end else begin
        case (state_reg)
          SEARCH: begin
            cand_next = narrowed;
            if (is_one_hot(narrowed)) begin
              conf_cnt_next = 8'd1;
              if (CONF_TARGET == 8'd1) begin
                state_next      = LOCKED;
                mode_next       = cand_to_mode(narrowed);
                mode_valid_next = 1'b1;
              end else begin
                state_next = CONFIRM;
              end
            end
          end
          CONFIRM: begin
            conf_cnt_next = conf_cnt_reg + 8'd1;
            if (conf_cnt_reg + 8'd1 == CONF_TARGET) begin
              state_next      = LOCKED;
              mode_next       = cand_to_mode(cand_reg);
              mode_valid_next = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign cand       = cand_reg;
  assign mode       = mode_reg;
  assign mode_valid = mode_valid_reg;
  assign err        = err_reg;
  assign sample_cnt = sample_cnt_reg;

endmodule
